// File: rtl/trap_ctrl_if.sv
// Commit-side bundle for trap_ctrl: event inputs, CSR read/write data and the fetch redirect handshake.
interface trap_ctrl_if;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic [31:0] ex_inst;
  logic        ex_ecall;
  logic        ex_illegal;
  logic        ex_mret;
  logic        timer_irq;
  logic [63:0] mstatus_rd_data;
  logic [63:0] mie_rd_data;
  logic [63:0] mtvec_rd_data;
  logic [63:0] mepc_rd_data;
  logic        excp_enter;
  logic        excp_exit;
  logic [63:0] mstatus_wr_data;
  logic [63:0] mepc_wr_data;
  logic [63:0] mcause_wr_data;
  logic [63:0] mtval_wr_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        redirect_ready;
  logic        busy;

  modport master (
    output ex_valid, ex_pc, ex_inst, ex_ecall, ex_illegal, ex_mret, timer_irq,
    output mstatus_rd_data, mie_rd_data, mtvec_rd_data, mepc_rd_data, redirect_ready,
    input  excp_enter, excp_exit, mstatus_wr_data, mepc_wr_data, mcause_wr_data,
    input  mtval_wr_data, redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  ex_valid, ex_pc, ex_inst, ex_ecall, ex_illegal, ex_mret, timer_irq,
    input  mstatus_rd_data, mie_rd_data, mtvec_rd_data, mepc_rd_data, redirect_ready,
    output excp_enter, excp_exit, mstatus_wr_data, mepc_wr_data, mcause_wr_data,
    output mtval_wr_data, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/trap_ctrl.sv
// M-mode trap/mret sequencer; timer interrupt path and vectored mtvec only with TRAP_TIMER_IRQ_EN.
// Strobe at N+1, redirect from N+2 held until redirect_ready; busy stalls commit for the whole sequence.
module trap_ctrl (
  input  logic       clk,
  input  logic       rst,
  trap_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ENTER, EXIT, REDIR} state_t;

  state_t      state;
  logic        irq_take;
  logic        trap_take;
  logic [63:0] tvec_base;
  logic [63:0] trap_pc;
  logic [63:0] trap_mstatus;
  logic [63:0] mret_mstatus;
  logic [63:0] trap_cause;
  logic [63:0] trap_tval;

  assign tvec_base = {bus.mtvec_rd_data[63:2], 2'b00};

`ifdef TRAP_TIMER_IRQ_EN
  logic unused_mie;
  assign unused_mie = ^{bus.mie_rd_data[63:8], bus.mie_rd_data[6:0]};
  assign irq_take   = bus.timer_irq & bus.mstatus_rd_data[3] & bus.mie_rd_data[7];
  // Only vectored mode offsets, and only for the interrupt (cause 7 -> +28).
  assign trap_pc    = (irq_take && bus.mtvec_rd_data[1:0] == 2'b01) ? tvec_base + 64'd28 : tvec_base;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{bus.timer_irq, bus.mie_rd_data, bus.mtvec_rd_data[1:0]};
  assign irq_take          = 1'b0;
  assign trap_pc           = tvec_base;
`endif

  assign trap_take = irq_take | bus.ex_illegal | bus.ex_ecall;

  always_comb begin
    trap_mstatus        = bus.mstatus_rd_data;
    trap_mstatus[7]     = bus.mstatus_rd_data[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = 2'b11;
    mret_mstatus        = bus.mstatus_rd_data;
    mret_mstatus[3]     = bus.mstatus_rd_data[7];
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[12:11] = 2'b11;
    trap_cause = irq_take ? 64'h8000_0000_0000_0007 : (bus.ex_illegal ? 64'd2 : 64'd11);
    trap_tval  = (!irq_take && bus.ex_illegal) ? {32'b0, bus.ex_inst} : 64'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      bus.excp_enter      <= 1'b0;
      bus.excp_exit       <= 1'b0;
      bus.redirect_valid  <= 1'b0;
      bus.redirect_pc     <= 64'b0;
      bus.busy            <= 1'b0;
      bus.mstatus_wr_data <= 64'b0;
      bus.mepc_wr_data    <= 64'b0;
      bus.mcause_wr_data  <= 64'b0;
      bus.mtval_wr_data   <= 64'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ex_valid && trap_take) begin
            state               <= ENTER;
            bus.busy            <= 1'b1;
            bus.excp_enter      <= 1'b1;
            bus.mstatus_wr_data <= trap_mstatus;
            bus.mepc_wr_data    <= bus.ex_pc;
            bus.mcause_wr_data  <= trap_cause;
            bus.mtval_wr_data   <= trap_tval;
            bus.redirect_pc     <= trap_pc;
          end else if (bus.ex_valid && bus.ex_mret) begin
            state               <= EXIT;
            bus.busy            <= 1'b1;
            bus.excp_exit       <= 1'b1;
            bus.mstatus_wr_data <= mret_mstatus;
            bus.redirect_pc     <= {bus.mepc_rd_data[63:2], 2'b00};
          end
        end
        ENTER, EXIT: begin
          state              <= REDIR;
          bus.excp_enter     <= 1'b0;
          bus.excp_exit      <= 1'b0;
          bus.redirect_valid <= 1'b1;
        end
        REDIR: begin
          if (bus.redirect_ready) begin
            state              <= IDLE;
            bus.redirect_valid <= 1'b0;
            bus.busy           <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expectations queued at drive time, popped when the CSR strobe appears.
module tb_trap_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trap_ctrl_if bus ();
  trap_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [63:0] mstatus;
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [63:0] mtval;
    logic [63:0] rpc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic set_idle();
    bus.ex_valid = 0; bus.ex_pc = 0; bus.ex_inst = 0;
    bus.ex_ecall = 0; bus.ex_illegal = 0; bus.ex_mret = 0; bus.timer_irq = 0;
    bus.mstatus_rd_data = 0; bus.mie_rd_data = 0; bus.mtvec_rd_data = 0; bus.mepc_rd_data = 0;
    bus.redirect_ready = 0;
  endtask

  // Presents one event for a single accept edge; returns in cycle N+1 with event flags dropped.
  task automatic drive_ev(input logic ecall, input logic illegal, input logic mret, input logic irq,
                          input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] mstatus,
                          input logic [63:0] mie, input logic [63:0] mtvec, input logic [63:0] mepc);
    @(negedge clk);
    bus.ex_valid = 1; bus.ex_ecall = ecall; bus.ex_illegal = illegal; bus.ex_mret = mret;
    bus.timer_irq = irq; bus.ex_pc = pc; bus.ex_inst = inst; bus.mstatus_rd_data = mstatus;
    bus.mie_rd_data = mie; bus.mtvec_rd_data = mtvec; bus.mepc_rd_data = mepc;
    @(negedge clk);
    bus.ex_valid = 0; bus.ex_ecall = 0; bus.ex_illegal = 0; bus.ex_mret = 0; bus.timer_irq = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    @(negedge clk);
    bus.ex_valid = 1; bus.ex_ecall = 1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.excp_enter !== 0 || bus.excp_exit !== 0 || bus.redirect_valid !== 0 || bus.busy !== 0) begin
      bad++; $display("FAIL reset_ctl enter=%b exit=%b rv=%b busy=%b want all 0",
                      bus.excp_enter, bus.excp_exit, bus.redirect_valid, bus.busy);
    end
    total++;
    if ((bus.redirect_pc | bus.mstatus_wr_data | bus.mepc_wr_data | bus.mcause_wr_data | bus.mtval_wr_data) !== 64'd0) begin
      bad++; $display("FAIL reset_data rpc=%h mst=%h mepc=%h mcause=%h mtval=%h want 0", bus.redirect_pc,
                      bus.mstatus_wr_data, bus.mepc_wr_data, bus.mcause_wr_data, bus.mtval_wr_data);
    end
    rst = 0;
    set_idle();
  endtask

  task automatic test_ecall();
    exp_t e;
    sb.push_back('{64'h1880, 64'h8000_0010, 64'd11, 64'd0, 64'h8000_1000});
    drive_ev(1, 0, 0, 0, 64'h8000_0010, 32'h0000_0073, 64'h1888, 64'h0, 64'h8000_1000, 64'h0);
    e = sb.pop_front();
    total++;
    if (bus.excp_enter !== 1 || bus.excp_exit !== 0 || bus.busy !== 1 || bus.redirect_valid !== 0) begin
      bad++; $display("FAIL ecall_n1 enter=%b exit=%b busy=%b rv=%b want 1 0 1 0",
                      bus.excp_enter, bus.excp_exit, bus.busy, bus.redirect_valid);
    end
    total++;
    if (bus.mstatus_wr_data !== e.mstatus || bus.mepc_wr_data !== e.mepc ||
        bus.mcause_wr_data !== e.mcause || bus.mtval_wr_data !== e.mtval) begin
      bad++; $display("FAIL ecall_data mst=%h mepc=%h mcause=%h mtval=%h want %h %h %h %h",
                      bus.mstatus_wr_data, bus.mepc_wr_data, bus.mcause_wr_data, bus.mtval_wr_data,
                      e.mstatus, e.mepc, e.mcause, e.mtval);
    end
    @(negedge clk);
    total++;
    if (bus.redirect_valid !== 1 || bus.redirect_pc !== e.rpc || bus.excp_enter !== 0) begin
      bad++; $display("FAIL ecall_redir rv=%b rpc=%h enter=%b want 1 %h 0",
                      bus.redirect_valid, bus.redirect_pc, bus.excp_enter, e.rpc);
    end
    bus.redirect_ready = 1;
    @(negedge clk);
    bus.redirect_ready = 0;
    total++;
    if (bus.redirect_valid !== 0 || bus.busy !== 0) begin
      bad++; $display("FAIL ecall_done rv=%b busy=%b want 0 0", bus.redirect_valid, bus.busy);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    // mtvec mode 3 falls back to direct.
    sb.push_back('{64'h1800, 64'h8000_0020, 64'd2, 64'hFFFF_FFFF, 64'h8000_2000});
    drive_ev(1, 1, 1, 0, 64'h8000_0020, 32'hFFFF_FFFF, 64'h0, 64'h0, 64'h8000_2003, 64'h0);
    e = sb.pop_front();
    total++;
    if (bus.excp_enter !== 1 || bus.mcause_wr_data !== e.mcause || bus.mtval_wr_data !== e.mtval ||
        bus.mstatus_wr_data !== e.mstatus || bus.mepc_wr_data !== e.mepc) begin
      bad++; $display("FAIL illegal_data enter=%b mcause=%h mtval=%h mst=%h mepc=%h want 1 %h %h %h %h",
                      bus.excp_enter, bus.mcause_wr_data, bus.mtval_wr_data, bus.mstatus_wr_data,
                      bus.mepc_wr_data, e.mcause, e.mtval, e.mstatus, e.mepc);
    end
    @(negedge clk);
    total++;
    if (bus.redirect_valid !== 1 || bus.redirect_pc !== e.rpc) begin
      bad++; $display("FAIL illegal_redir rv=%b rpc=%h want 1 %h", bus.redirect_valid, bus.redirect_pc, e.rpc);
    end
    bus.redirect_ready = 1;
    @(negedge clk);
    bus.redirect_ready = 0;
  endtask

  task automatic test_mret();
    exp_t e;
    sb.push_back('{64'h1888, 64'h0, 64'h0, 64'h0, 64'h8000_0014});
    drive_ev(0, 0, 1, 0, 64'h8000_0100, 32'h3020_0073, 64'h1880, 64'h0, 64'h0, 64'h8000_0014);
    e = sb.pop_front();
    total++;
    if (bus.excp_exit !== 1 || bus.excp_enter !== 0 || bus.mstatus_wr_data !== e.mstatus) begin
      bad++; $display("FAIL mret_n1 exit=%b enter=%b mst=%h want 1 0 %h",
                      bus.excp_exit, bus.excp_enter, bus.mstatus_wr_data, e.mstatus);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.redirect_valid !== 1 || bus.busy !== 1 || bus.redirect_pc !== e.rpc || bus.excp_exit !== 0) begin
        bad++; $display("FAIL mret_hold%0d rv=%b busy=%b rpc=%h exit=%b want 1 1 %h 0", i,
                        bus.redirect_valid, bus.busy, bus.redirect_pc, bus.excp_exit, e.rpc);
      end
    end
    bus.redirect_ready = 1;
    @(negedge clk);
    bus.redirect_ready = 0;
    total++;
    if (bus.redirect_valid !== 0 || bus.busy !== 0) begin
      bad++; $display("FAIL mret_done rv=%b busy=%b want 0 0", bus.redirect_valid, bus.busy);
    end
  endtask

  task automatic test_irq();
    exp_t e;
    // Pending interrupt without a committing instruction must not trap.
    @(negedge clk);
    bus.timer_irq = 1; bus.mstatus_rd_data = 64'h1888; bus.mie_rd_data = 64'h80;
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy !== 0 || bus.excp_enter !== 0) begin
      bad++; $display("FAIL irq_no_valid busy=%b enter=%b want 0 0", bus.busy, bus.excp_enter);
    end
`ifdef TRAP_TIMER_IRQ_EN
    sb.push_back('{64'h1880, 64'h8000_0200, 64'h8000_0000_0000_0007, 64'd0, 64'h8000_101C});
`else
    sb.push_back('{64'h1880, 64'h8000_0200, 64'd11, 64'd0, 64'h8000_1000});
`endif
    drive_ev(1, 0, 0, 1, 64'h8000_0200, 32'h0000_0073, 64'h1888, 64'h80, 64'h8000_1001, 64'h0);
    e = sb.pop_front();
    total++;
    if (bus.excp_enter !== 1 || bus.mcause_wr_data !== e.mcause || bus.mepc_wr_data !== e.mepc ||
        bus.mstatus_wr_data !== e.mstatus || bus.mtval_wr_data !== e.mtval) begin
      bad++; $display("FAIL irq_data enter=%b mcause=%h mepc=%h mst=%h mtval=%h want 1 %h %h %h %h",
                      bus.excp_enter, bus.mcause_wr_data, bus.mepc_wr_data, bus.mstatus_wr_data,
                      bus.mtval_wr_data, e.mcause, e.mepc, e.mstatus, e.mtval);
    end
    @(negedge clk);
    total++;
    if (bus.redirect_valid !== 1 || bus.redirect_pc !== e.rpc) begin
      bad++; $display("FAIL irq_redir rv=%b rpc=%h want 1 %h", bus.redirect_valid, bus.redirect_pc, e.rpc);
    end
    bus.redirect_ready = 1;
    @(negedge clk);
    bus.redirect_ready = 0;
    // MIE clear: the ecall wins and vectored mode gives the base for exceptions.
    sb.push_back('{64'h1800, 64'h8000_0204, 64'd11, 64'd0, 64'h8000_1000});
    drive_ev(1, 0, 0, 1, 64'h8000_0204, 32'h0000_0073, 64'h1880, 64'h80, 64'h8000_1001, 64'h0);
    e = sb.pop_front();
    total++;
    if (bus.excp_enter !== 1 || bus.mcause_wr_data !== e.mcause || bus.mstatus_wr_data !== e.mstatus) begin
      bad++; $display("FAIL irq_masked enter=%b mcause=%h mst=%h want 1 %h %h",
                      bus.excp_enter, bus.mcause_wr_data, bus.mstatus_wr_data, e.mcause, e.mstatus);
    end
    @(negedge clk);
    total++;
    if (bus.redirect_pc !== e.rpc) begin
      bad++; $display("FAIL irq_masked_redir rpc=%h want %h", bus.redirect_pc, e.rpc);
    end
    bus.redirect_ready = 1;
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sb.push_back('{64'h1800, 64'h8000_0100, 64'd11, 64'd0, 64'h8000_1000});
    drive_ev(1, 0, 0, 0, 64'h8000_0100, 32'h0000_0073, 64'h0, 64'h0, 64'h8000_1001, 64'h0);
    e = sb.pop_front();
    total++;
    if (bus.excp_enter !== 1 || bus.mcause_wr_data !== e.mcause) begin
      bad++; $display("FAIL b2b_first enter=%b mcause=%h want 1 %h", bus.excp_enter, bus.mcause_wr_data, e.mcause);
    end
    bus.ex_valid = 1; bus.ex_illegal = 1; bus.ex_mret = 1;
    @(negedge clk);
    total++;
    if (bus.excp_enter !== 0 || bus.excp_exit !== 0 || bus.redirect_valid !== 1 || bus.redirect_pc !== e.rpc) begin
      bad++; $display("FAIL b2b_busy_ignore enter=%b exit=%b rv=%b rpc=%h want 0 0 1 %h",
                      bus.excp_enter, bus.excp_exit, bus.redirect_valid, bus.redirect_pc, e.rpc);
    end
    bus.redirect_ready = 1;
    @(negedge clk);
    total++;
    if (bus.busy !== 0 || bus.excp_enter !== 0 || bus.excp_exit !== 0 || bus.redirect_valid !== 0) begin
      bad++; $display("FAIL b2b_gap busy=%b enter=%b exit=%b rv=%b want 0 0 0 0",
                      bus.busy, bus.excp_enter, bus.excp_exit, bus.redirect_valid);
    end
    bus.redirect_ready = 0;
    bus.ex_illegal = 0; bus.ex_mret = 1; bus.mstatus_rd_data = 64'h0; bus.mepc_rd_data = 64'h8000_0017;
    sb.push_back('{64'h1880, 64'h0, 64'h0, 64'h0, 64'h8000_0014});
    @(negedge clk);
    set_idle();
    e = sb.pop_front();
    total++;
    if (bus.excp_exit !== 1 || bus.mstatus_wr_data !== e.mstatus) begin
      bad++; $display("FAIL b2b_second exit=%b mst=%h want 1 %h", bus.excp_exit, bus.mstatus_wr_data, e.mstatus);
    end
    @(negedge clk);
    total++;
    if (bus.redirect_pc !== e.rpc || bus.redirect_valid !== 1) begin
      bad++; $display("FAIL b2b_second_redir rpc=%h rv=%b want %h 1", bus.redirect_pc, bus.redirect_valid, e.rpc);
    end
    bus.redirect_ready = 1;
    @(negedge clk);
    bus.redirect_ready = 0;
    bus.ex_valid = 1;
    repeat (2) @(negedge clk);
    bus.ex_valid = 0;
    total++;
    if (bus.busy !== 0 || bus.excp_enter !== 0 || bus.excp_exit !== 0) begin
      bad++; $display("FAIL no_event busy=%b enter=%b exit=%b want 0 0 0", bus.busy, bus.excp_enter, bus.excp_exit);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    sb.push_back('{64'h1880, 64'h8000_0300, 64'd11, 64'd0, 64'h8000_1000});
    drive_ev(1, 0, 0, 0, 64'h8000_0300, 32'h0000_0073, 64'h1888, 64'h0, 64'h8000_1000, 64'h0);
    e = sb.pop_front();
    @(negedge clk);
    total++;
    if (bus.redirect_valid !== 1 || bus.redirect_pc !== e.rpc) begin
      bad++; $display("FAIL abort_pre rv=%b rpc=%h want 1 %h", bus.redirect_valid, bus.redirect_pc, e.rpc);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    total++;
    if (bus.redirect_valid !== 0 || bus.busy !== 0 || bus.redirect_pc !== 0 || bus.mcause_wr_data !== 0) begin
      bad++; $display("FAIL abort_redir rv=%b busy=%b rpc=%h mcause=%h want 0 0 0 0",
                      bus.redirect_valid, bus.busy, bus.redirect_pc, bus.mcause_wr_data);
    end
    sb.push_back('{64'h1880, 64'h8000_0304, 64'd11, 64'd0, 64'h8000_1000});
    drive_ev(1, 0, 0, 0, 64'h8000_0304, 32'h0000_0073, 64'h1888, 64'h0, 64'h8000_1000, 64'h0);
    e = sb.pop_front();
    total++;
    if (bus.excp_enter !== 1 || bus.mepc_wr_data !== e.mepc) begin
      bad++; $display("FAIL abort_enter_pre enter=%b mepc=%h want 1 %h", bus.excp_enter, bus.mepc_wr_data, e.mepc);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    total++;
    if (bus.excp_enter !== 0 || bus.redirect_valid !== 0 || bus.busy !== 0) begin
      bad++; $display("FAIL abort_enter enter=%b rv=%b busy=%b want 0 0 0", bus.excp_enter, bus.redirect_valid, bus.busy);
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_ecall();
    test_illegal();
    test_mret();
    test_irq();
    test_back_to_back();
    test_reset_abort();
    total++;
    if (sb.size() !== 0) begin
      bad++; $display("FAIL scoreboard_left size=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 ex_valid  in  1  instruction at commit point this cycle.
REQ-004 ex_pc  in  64  PC of committing instruction.
REQ-005 ex_inst  in  32  raw encoding of committing instruction.
REQ-006 ex_ecall / ex_illegal / ex_mret  in  1 each  decoded event flags, meaningful only with ex_valid.
REQ-007 timer_irq  in  1  level machine-timer interrupt request.
REQ-008 mstatus_rd_data / mie_rd_data / mtvec_rd_data / mepc_rd_data  in  64 each  current CSR values.
REQ-009 excp_enter / excp_exit  out  1 each  one-cycle CSR update strobes.
REQ-010 mstatus_wr_data / mepc_wr_data / mcause_wr_data / mtval_wr_data  out  64 each  registered CSR write data, valid while a strobe is high.
REQ-011 redirect_valid  out  1; redirect_pc  out  64; redirect_ready  in  1  fetch redirect handshake.
REQ-012 busy  out  1  high whenever state != IDLE; upstream holds commit.

Function
REQ-013 FSM states: IDLE, ENTER, EXIT, REDIR.
REQ-014 In IDLE with ex_valid, the event is selected by priority: interrupt > illegal > ecall > mret; no event -> stay IDLE.
REQ-015 Interrupt taken iff timer_irq & mstatus[3] (MIE) & mie[7] (MTIE) & ex_valid; that instruction is not executed.
REQ-016 Trap accept (cycle N): -> ENTER; mepc_wr_data=ex_pc; mcause_wr_data = 64'h8000_0000_0000_0007 (interrupt), 2 (illegal), 11 (ecall); mtval_wr_data = zero-extended ex_inst for illegal, else 0.
REQ-017 Trap mstatus_wr_data = mstatus_rd_data with bit7 <= bit3, bit3 <= 0, bits[12:11] <= 2'b11.
REQ-018 Trap redirect_pc: mtvec[1:0]==0 -> {mtvec[63:2],2'b00}; mtvec[1:0]==1 and interrupt -> {mtvec[63:2],2'b00} + 4*7; mtvec[1:0]==1 and exception -> base; mtvec[1:0]>=2 treated as direct.
REQ-019 mret accept (cycle N): -> EXIT; mstatus_wr_data = mstatus_rd_data with bit3 <= bit7, bit7 <= 1, bits[12:11] <= 2'b11; redirect_pc = mepc_rd_data with bits[1:0] cleared.
REQ-020 All write data and redirect_pc are captured in cycle N from CSR inputs of cycle N.
REQ-021 ENTER: excp_enter=1 for exactly one cycle (N+1), then -> REDIR. EXIT: excp_exit=1 for exactly one cycle (N+1), then -> REDIR.
REQ-022 REDIR: redirect_valid=1 from N+2, redirect_pc stable, held until redirect_ready=1; on that cycle -> IDLE.
REQ-023 excp_enter and excp_exit are never high together; redirect_valid never high outside REDIR.
REQ-024 ex_valid and all event inputs ignored while busy; timer_irq changes while busy have no effect on the in-flight event.
REQ-025 Minimum event-to-event spacing: 3 cycles (N, N+1, N+2 with ready=1); next accept at N+3.

Reset
REQ-026 rst in any state -> IDLE next edge, aborting in-flight event with no strobe or redirect emitted.
REQ-027 Reset values: excp_enter=0, excp_exit=0, redirect_valid=0, busy=0, redirect_pc=0, all *_wr_data=0.

Configuration
REQ-028 Macro TRAP_TIMER_IRQ_EN: defined -> REQ-015 interrupt path and vectored offset active; undefined -> timer_irq ignored, only ecall/illegal/mret handled, mtvec mode treated as direct.

Verification
REQ-029 Reset: rst=1 two cycles -> all outputs 0, busy=0.
REQ-030 ecall at ex_pc=0x8000_0010, mtvec=0x8000_1000, mstatus=0x1888 -> N+1 excp_enter=1, mepc=0x8000_0010, mcause=11, mstatus_wr=0x1880; N+2 redirect_pc=0x8000_1000.
REQ-031 Illegal ex_inst=0xFFFF_FFFF with ecall also set -> mcause=2, mtval=0xFFFF_FFFF.
REQ-032 mret with mepc=0x8000_0014, mstatus=0x1880 -> N+1 excp_exit=1, mstatus_wr=0x1888; redirect_pc=0x8000_0014; redirect_ready low 3 cycles -> redirect_valid held 3 cycles, busy high.
REQ-033 TRAP_TIMER_IRQ_EN defined, timer_irq=1, MIE=1, MTIE=1, mtvec=0x8000_1001, ecall also set -> mcause=0x8000_0000_0000_0007, redirect_pc=0x8000_101C; with MIE=0 -> ecall taken instead.
REQ-034 rst asserted during REDIR -> next cycle IDLE, redirect_valid=0; ex_valid during busy -> no second strobe.
